user_cnn_ctrl: RTL and testbench

OBI subordinate that configures and sequences the user-domain CNN accelerator tile by tile. It sits on the user demux port UserCnn at 0x2000_1000, with a 4 KiB window. Software programs a tile count and a per-tile timeout, then starts a job. The block issues tiles to the CNN datapath over a valid/ready handshake, waits for each tile's completion, and raises a level interrupt when the job finishes.

---
 rtl/user_cnn_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_user_cnn_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/user_cnn_ctrl.sv
// user_cnn_ctrl: OBI subordinate that configures and sequences the CNN
// accelerator tile by tile.
//   clk_i, rst_ni          : clock, asynchronous active-low reset
//   obi_*                  : OBI subordinate port. Grant is always given and
//                            the response follows one cycle after the request.
//   tile_valid_o/ready_i   : tile issue handshake towards the CNN datapath
//   tile_idx_o             : index of the tile being issued or processed
//   tile_done_i            : single-cycle completion pulse for the current tile
//   irq_o                  : level interrupt, registered DONE & IRQ_EN
// Register map (addr[4:2]): 0 CTRL, 1 STATUS, 2 NUM_TILES, 3 TILE_IDX, 4 TIMEOUT.
module user_cnn_ctrl #(
  parameter int IdWidth  = 1,
  parameter int CntWidth = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                obi_req_i,
  output logic                obi_gnt_o,
  input  logic [31:0]         obi_addr_i,
  input  logic                obi_we_i,
  input  logic [3:0]          obi_be_i,
  input  logic [31:0]         obi_wdata_i,
  input  logic [IdWidth-1:0]  obi_aid_i,
  output logic                obi_rvalid_o,
  output logic [31:0]         obi_rdata_o,
  output logic [IdWidth-1:0]  obi_rid_o,
  output logic                obi_err_o,
  output logic                tile_valid_o,
  input  logic                tile_ready_i,
  output logic [CntWidth-1:0] tile_idx_o,
  input  logic                tile_done_i,
  output logic                irq_o
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_FINISH} state_t;

  state_t r_state;
  state_t w_state_next;

  logic                r_rvalid;
  logic [31:0]         r_rdata;
  logic [IdWidth-1:0]  r_rid;
  logic                r_err;
  logic                r_irq_en;
  logic                r_done;
  logic                r_to_flag;
  logic [CntWidth-1:0] r_num_tiles;
  logic [CntWidth-1:0] r_timeout_val;
  logic [CntWidth-1:0] r_idx;
  logic [CntWidth-1:0] r_timer;
  logic                r_irq;

  logic [2:0]          w_reg_idx;
  logic                w_wr;
  logic                w_rd;
  logic                w_addr_ok;
  logic                w_busy;
  logic                w_ctrl_wr;
  logic                w_stat_wr;
  logic                w_start;
  logic                w_abort;
  logic                w_last;
  logic                w_expire;
  logic [31:0]         w_be_mask;
  logic [CntWidth-1:0] w_mask;
  logic [CntWidth-1:0] w_num_merge;
  logic [CntWidth-1:0] w_to_merge;
  logic [31:0]         w_rdata;
  logic                w_unused;

  assign w_reg_idx = obi_addr_i[4:2];
  assign w_wr      = obi_req_i & obi_we_i;
  assign w_rd      = obi_req_i & ~obi_we_i;
  assign w_addr_ok = (w_reg_idx <= 3'd4);
  assign w_busy    = (r_state != S_IDLE);
  assign w_ctrl_wr = w_wr & (w_reg_idx == 3'd0) & obi_be_i[0];
  assign w_stat_wr = w_wr & (w_reg_idx == 3'd1) & obi_be_i[0];
  // ABORT takes precedence over a START carried in the same write.
  assign w_abort   = w_ctrl_wr & obi_wdata_i[2];
  assign w_start   = w_ctrl_wr & obi_wdata_i[0] & ~obi_wdata_i[2];
  assign w_last    = (r_idx == r_num_tiles - CntWidth'(1));
  // A done pulse in the expiry cycle wins over the timeout.
  assign w_expire  = (r_timeout_val != '0) &&
                     (r_timer == r_timeout_val - CntWidth'(1)) && !tile_done_i;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_be
      assign w_be_mask[gi*8 +: 8] = {8{obi_be_i[gi]}};
    end
  endgenerate

  assign w_mask      = w_be_mask[CntWidth-1:0];
  assign w_num_merge = (r_num_tiles & ~w_mask) | (obi_wdata_i[CntWidth-1:0] & w_mask);
  assign w_to_merge  = (r_timeout_val & ~w_mask) | (obi_wdata_i[CntWidth-1:0] & w_mask);

  always_comb begin
    w_rdata = '0;
    case (w_reg_idx)
      3'd0:    w_rdata = {30'd0, r_irq_en, 1'b0};
      3'd1:    w_rdata = {29'd0, r_to_flag, r_done, w_busy};
      3'd2:    w_rdata = 32'(r_num_tiles);
      3'd3:    w_rdata = 32'(r_idx);
      3'd4:    w_rdata = 32'(r_timeout_val);
      default: w_rdata = '0;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (w_start && r_num_tiles != '0) w_state_next = S_ISSUE;
      S_ISSUE: begin
        if (w_abort)           w_state_next = S_IDLE;
        else if (tile_ready_i) w_state_next = S_WAIT;
      end
      S_WAIT: begin
        if (w_abort)          w_state_next = S_IDLE;
        else if (tile_done_i) w_state_next = w_last ? S_FINISH : S_ISSUE;
        else if (w_expire)    w_state_next = S_IDLE;
      end
      S_FINISH: w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rvalid      <= 1'b0;
      r_rdata       <= '0;
      r_rid         <= '0;
      r_err         <= 1'b0;
      r_irq_en      <= 1'b0;
      r_done        <= 1'b0;
      r_to_flag     <= 1'b0;
      r_num_tiles   <= '0;
      r_timeout_val <= '0;
      r_idx         <= '0;
      r_timer       <= '0;
      r_irq         <= 1'b0;
    end else begin
      r_rvalid <= obi_req_i;
      r_err    <= obi_req_i & ~w_addr_ok;
      r_rdata  <= w_rd ? w_rdata : 32'd0;
      if (obi_req_i) r_rid <= obi_aid_i;

      if (w_ctrl_wr) r_irq_en <= obi_wdata_i[1];
      if (w_wr && w_reg_idx == 3'd2 && !w_busy) r_num_tiles   <= w_num_merge;
      if (w_wr && w_reg_idx == 3'd4 && !w_busy) r_timeout_val <= w_to_merge;

      // DONE: set on job completion or on an empty job, cleared by a new job
      // or a write-1 to STATUS.
      if (r_state == S_FINISH)                   r_done <= 1'b1;
      else if (r_state == S_IDLE && w_start)     r_done <= (r_num_tiles == '0);
      else if (w_stat_wr && obi_wdata_i[1])      r_done <= 1'b0;

      if (r_state == S_WAIT && !w_abort && w_expire)                   r_to_flag <= 1'b1;
      else if (r_state == S_IDLE && w_start && r_num_tiles != '0)      r_to_flag <= 1'b0;
      else if (w_stat_wr && obi_wdata_i[2])                            r_to_flag <= 1'b0;

      if (r_state == S_IDLE && w_start && r_num_tiles != '0)
        r_idx <= '0;
      else if (r_state == S_WAIT && !w_abort && tile_done_i && !w_last)
        r_idx <= r_idx + CntWidth'(1);

      if (r_state == S_ISSUE && tile_ready_i) r_timer <= '0;
      else if (r_state == S_WAIT)             r_timer <= r_timer + CntWidth'(1);

      r_irq <= r_done & r_irq_en;
    end
  end

  assign obi_gnt_o    = 1'b1;
  assign obi_rvalid_o = r_rvalid;
  assign obi_rdata_o  = r_rdata;
  assign obi_rid_o    = r_rid;
  assign obi_err_o    = r_err;
  assign tile_valid_o = (r_state == S_ISSUE);
  assign tile_idx_o   = r_idx;
  assign irq_o        = r_irq;

  // Address bits outside [4:2] and wide data/strobe bits are not decoded.
  assign w_unused = ^{obi_addr_i[31:5], obi_addr_i[1:0], obi_wdata_i, obi_be_i};

endmodule

// File: tb/tb_user_cnn_ctrl.sv
module tb_user_cnn_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        req, gnt, we, rvalid, rerr, aid, rid;
  logic [31:0] addr, wdata, rdata;
  logic [3:0]  be;
  logic        tile_valid, tile_ready, tile_done, irq;
  logic [15:0] tile_idx;

  int vec_cnt = 0;
  int err_cnt = 0;

  // CNN model state
  int          hs_count = 0;
  int          vcnt = 0;
  int          dcnt = 0;
  bit          done_en = 1'b0;
  logic [15:0] idx_log [0:63];

  always #5 clk = ~clk;

  user_cnn_ctrl #(.IdWidth(1), .CntWidth(16)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .obi_req_i(req), .obi_gnt_o(gnt), .obi_addr_i(addr), .obi_we_i(we),
    .obi_be_i(be), .obi_wdata_i(wdata), .obi_aid_i(aid),
    .obi_rvalid_o(rvalid), .obi_rdata_o(rdata), .obi_rid_o(rid), .obi_err_o(rerr),
    .tile_valid_o(tile_valid), .tile_ready_i(tile_ready), .tile_idx_o(tile_idx),
    .tile_done_i(tile_done), .irq_o(irq)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One OBI transaction: request in the current cycle, response sampled at
  // the next negedge.
  task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] b, input logic id,
                     output logic [31:0] rd_data, output logic rd_err);
    req = 1'b1; we = w; addr = a; wdata = d; be = b; aid = id;
    @(posedge clk);
    #1 req = 1'b0; we = 1'b0;
    @(negedge clk);
    check("rvalid", {31'd0, rvalid}, 32'd1);
    check("rid", {31'd0, rid}, {31'd0, id});
    rd_data = rdata;
    rd_err  = rerr;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic exp_err);
    logic [31:0] dd;
    logic        ee;
    bus(1'b1, a, d, 4'hF, 1'b0, dd, ee);
    check($sformatf("wr_err@%0h", a), {31'd0, ee}, {31'd0, exp_err});
  endtask

  task automatic rd(input string tag, input logic [31:0] a,
                    input logic [31:0] exp_d, input logic exp_err);
    logic [31:0] dd;
    logic        ee;
    bus(1'b0, a, 32'd0, 4'hF, 1'b1, dd, ee);
    check(tag, dd, exp_d);
    check({tag, "_err"}, {31'd0, ee}, {31'd0, exp_err});
  endtask

  // CNN model: ready two cycles after valid is seen, done five cycles after
  // the handshake (when enabled).
  initial begin
    tile_ready = 1'b0;
    tile_done  = 1'b0;
    forever begin
      @(negedge clk);
      tile_done = 1'b0;
      if (dcnt > 0) begin
        dcnt--;
        if (dcnt == 0) tile_done = 1'b1;
      end
      if (tile_ready) begin
        tile_ready = 1'b0;
        idx_log[hs_count] = tile_idx;
        hs_count++;
        if (done_en) dcnt = 5;
      end else if (tile_valid) begin
        vcnt++;
        if (vcnt == 2) begin
          vcnt = 0;
          tile_ready = 1'b1;
        end
      end
    end
  end

  initial begin
    int base;
    logic [31:0] dd;
    logic        ee;
    req = 1'b0; we = 1'b0; addr = '0; wdata = '0; be = '0; aid = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tile_valid", {31'd0, tile_valid}, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_rvalid", {31'd0, rvalid}, 32'd0);
    check("rst_tile_idx", {16'd0, tile_idx}, 32'd0);
    check("gnt", {31'd0, gnt}, 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset register values and decode
    rd("rst_ctrl",    32'h00, 32'd0, 1'b0);
    rd("rst_status",  32'h04, 32'd0, 1'b0);
    rd("rst_num",     32'h08, 32'd0, 1'b0);
    rd("rst_idx",     32'h0C, 32'd0, 1'b0);
    rd("rst_timeout", 32'h10, 32'd0, 1'b0);
    rd("bad_rd",      32'h14, 32'd0, 1'b1);
    wr(32'h18, 32'hFFFF, 1'b1);
    wr(32'h0C, 32'h1234, 1'b0);
    rd("ro_idx", 32'h0C, 32'd0, 1'b0);

    // Byte enables: only the low byte lands
    bus(1'b1, 32'h08, 32'h0000ABCD, 4'b0001, 1'b0, dd, ee);
    rd("be_num", 32'h08, 32'h0000_00CD, 1'b0);

    // Three-tile job with interrupt
    done_en = 1'b1;
    base = hs_count;
    wr(32'h08, 32'd3, 1'b0);
    wr(32'h00, 32'h3, 1'b0);
    repeat (60) @(negedge clk);
    #1;
    check("job_hs", hs_count - base, 32'd3);
    for (int i = 0; i < 3; i++)
      check($sformatf("job_idx%0d", i), {16'd0, idx_log[base+i]}, i);
    rd("job_status", 32'h04, 32'h2, 1'b0);
    rd("job_tile_idx", 32'h0C, 32'd2, 1'b0);
    check("job_irq", {31'd0, irq}, 32'd1);
    wr(32'h04, 32'h2, 1'b0);
    check("irq_hold", {31'd0, irq}, 32'd1);
    @(negedge clk);
    check("irq_drop", {31'd0, irq}, 32'd0);

    // Empty job: DONE immediately, nothing issued
    base = hs_count;
    wr(32'h08, 32'd0, 1'b0);
    wr(32'h00, 32'h3, 1'b0);
    rd("zero_status", 32'h04, 32'h2, 1'b0);
    check("zero_irq", {31'd0, irq}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      check("zero_valid", {31'd0, tile_valid}, 32'd0);
      @(negedge clk);
    end
    check("zero_hs", hs_count - base, 32'd0);

    // Timeout: CNN never reports done
    done_en = 1'b0;
    wr(32'h10, 32'd8, 1'b0);
    wr(32'h08, 32'd2, 1'b0);
    base = hs_count;
    wr(32'h00, 32'h3, 1'b0);
    rd("to_busy", 32'h04, 32'h1, 1'b0);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      #1;
      if (hs_count != base) break;
    end
    check("to_hs", hs_count - base, 32'd1);
    repeat (7) @(negedge clk);
    rd("to_pre", 32'h04, 32'h1, 1'b0);
    rd("to_status", 32'h04, 32'h4, 1'b0);
    rd("to_tile_idx", 32'h0C, 32'd0, 1'b0);
    check("to_irq", {31'd0, irq}, 32'd0);

    // Abort during WAIT of tile 1
    done_en = 1'b1;
    wr(32'h10, 32'd0, 1'b0);
    wr(32'h08, 32'd4, 1'b0);
    base = hs_count;
    wr(32'h00, 32'h3, 1'b0);
    wr(32'h08, 32'd9, 1'b0);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      #1;
      if (hs_count - base >= 2) break;
    end
    check("ab_hs", hs_count - base, 32'd2);
    wr(32'h00, 32'h6, 1'b0);
    rd("ab_status", 32'h04, 32'h0, 1'b0);
    rd("ab_tile_idx", 32'h0C, 32'd1, 1'b0);
    rd("ab_num", 32'h08, 32'd4, 1'b0);
    rd("ab_ctrl", 32'h00, 32'h2, 1'b0);

    // Back-to-back reads with aid 0 then 1
    req = 1'b1; we = 1'b0; addr = 32'h08; be = 4'hF; aid = 1'b0;
    @(posedge clk);
    #1 aid = 1'b1;
    @(negedge clk);
    check("b2b_rvalid0", {31'd0, rvalid}, 32'd1);
    check("b2b_rid0", {31'd0, rid}, 32'd0);
    check("b2b_rdata0", rdata, 32'd4);
    @(posedge clk);
    #1 req = 1'b0;
    @(negedge clk);
    check("b2b_rvalid1", {31'd0, rvalid}, 32'd1);
    check("b2b_rid1", {31'd0, rid}, 32'd1);
    check("b2b_rdata1", rdata, 32'd4);
    @(negedge clk);
    check("b2b_idle", {31'd0, rvalid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
